// File: rtl/inv_perm_pkg.sv
// Shared definitions for the decrypt-side inverse byte-permutation stage.
// Key-select codes, the occupancy encoding and the byte-source table.
// Optional feature macro used by the stage: INV_PERM_BYPASS_EN.
package inv_perm_pkg;

  localparam logic [1:0] SEL_OUT_R = 2'b00;
  localparam logic [1:0] SEL_IN_R  = 2'b01;
  localparam logic [1:0] SEL_IN_L  = 2'b10;
  localparam logic [1:0] SEL_OUT_L = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  // Flat byte position of row r, column j.
  function automatic int byte_idx(input int r, input int j);
    return 4 * r + j;
  endfunction

  // Input byte that lands on output byte (r,j) for a given key select.
  // Any byte not named by a select's rule passes straight through.
  function automatic int src_idx(input logic [1:0] sel, input int r, input int j);
    int s;
    s = byte_idx(r, j);
    case (sel)
      SEL_OUT_R: begin
        if (r == 0)      s = byte_idx(j, 3);
        else if (r == 3) s = byte_idx(j, 0);
        else if (j == 0) s = byte_idx(0, 3 - r);
        else if (j == 3) s = byte_idx(3, 3 - r);
      end
      SEL_OUT_L: begin
        if (r == 0)      s = byte_idx(3 - j, 0);
        else if (r == 3) s = byte_idx(3 - j, 3);
        else if (j == 0) s = byte_idx(3, r);
        else if (j == 3) s = byte_idx(0, r);
      end
      SEL_IN_R: begin
        if (r == 1 && j == 1)      s = byte_idx(1, 2);
        else if (r == 1 && j == 2) s = byte_idx(2, 2);
        else if (r == 2 && j == 1) s = byte_idx(1, 1);
        else if (r == 2 && j == 2) s = byte_idx(2, 1);
      end
      default: begin
        if (r == 1 && j == 1)      s = byte_idx(2, 1);
        else if (r == 1 && j == 2) s = byte_idx(1, 1);
        else if (r == 2 && j == 1) s = byte_idx(2, 2);
        else if (r == 2 && j == 2) s = byte_idx(1, 2);
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/inv_perm_map.sv
// Purely combinational inverse byte permutation: (state, sel) -> mapped.
// Each output byte is a 4:1 mux over the constant sources for the four selects.
module inv_perm_map
  import inv_perm_pkg::*;
#(
  parameter int BYTE_W = 8
) (
  input  logic [16*BYTE_W-1:0] state,
  input  logic [1:0]           sel,
  output logic [16*BYTE_W-1:0] mapped
);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int S_OR = src_idx(SEL_OUT_R, gi / 4, gi % 4);
      localparam int S_IR = src_idx(SEL_IN_R,  gi / 4, gi % 4);
      localparam int S_IL = src_idx(SEL_IN_L,  gi / 4, gi % 4);
      localparam int S_OL = src_idx(SEL_OUT_L, gi / 4, gi % 4);

      assign mapped[gi*BYTE_W +: BYTE_W] =
        (sel == SEL_OUT_R) ? state[S_OR*BYTE_W +: BYTE_W] :
        (sel == SEL_IN_R)  ? state[S_IR*BYTE_W +: BYTE_W] :
        (sel == SEL_IN_L)  ? state[S_IL*BYTE_W +: BYTE_W] :
                             state[S_OL*BYTE_W +: BYTE_W];
    end
  endgenerate

endmodule

// File: rtl/inv_perm_stage.sv
// Decrypt pipeline stage: inverse-permutes a 4x4 byte state by key select and
// registers it behind a valid/ready handshake with a 2-entry skid buffer.
// SKID=1 gives a registered in_ready; SKID=0 is a single register stage.
// Optional macro INV_PERM_BYPASS_EN adds in_bypass: such beats pass unpermuted.
module inv_perm_stage
  import inv_perm_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int SKID   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*BYTE_W-1:0] in_state,
  input  logic [1:0]           in_key,
`ifdef INV_PERM_BYPASS_EN
  input  logic                 in_bypass,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*BYTE_W-1:0] out_state
);

  localparam int W = 16 * BYTE_W;

  occ_t         occ;
  occ_t         occ_next;
  logic         ready_reg;
  logic [W-1:0] mapped;
  logic [W-1:0] beat;
  logic [W-1:0] skid_state;
  logic         in_fire;
  logic         out_fire;
  logic         load_out;
  logic         load_skid;
  logic         from_skid;

  inv_perm_map #(.BYTE_W(BYTE_W)) u_map (
    .state  (in_state),
    .sel    (in_key),
    .mapped (mapped)
  );

  // The bypass choice is resolved before capture, so whichever register holds
  // the beat (out or skid) already carries the right data for it.
`ifdef INV_PERM_BYPASS_EN
  assign beat = in_bypass ? in_state : mapped;
`else
  assign beat = mapped;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Occupancy register; in_ready is precomputed from the next occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ       <= EMPTY;
      ready_reg <= 1'b1;
    end else begin
      occ       <= occ_next;
      ready_reg <= (occ_next != FULL);
    end
  end

  // Next occupancy from the two handshakes.
  always_comb begin
    occ_next = occ;
    case (occ)
      EMPTY: if (in_fire) occ_next = ONE;
      ONE: begin
        if (in_fire && !out_fire)      occ_next = FULL;
        else if (out_fire && !in_fire) occ_next = EMPTY;
      end
      FULL:    if (out_fire) occ_next = ONE;
      default: occ_next = EMPTY;
    endcase
  end

  // Handshake outputs decoded from occupancy (FULL is unreachable when SKID=0).
  always_comb begin
    out_valid = (occ != EMPTY);
    in_ready  = (SKID != 0) ? ready_reg : ((occ == EMPTY) | out_ready);
  end

  assign load_out  = in_fire & ((occ == EMPTY) | ((occ == ONE) & out_fire));
  assign load_skid = in_fire & (occ == ONE) & ~out_fire;
  assign from_skid = out_fire & (occ == FULL);

  // Output and skid data registers; the skid beat is older, so it wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state  <= '0;
      skid_state <= '0;
    end else begin
      if (from_skid)     out_state <= skid_state;
      else if (load_out) out_state <= beat;
      if (load_skid)     skid_state <= beat;
    end
  end

endmodule
